scaled_view_renderer: RTL
=========================

Name: scaled_view_renderer

Overview:
- Parametrised full-screen background renderer.
- Stretches a VIEW_W x SRC_H window of a SRC_W x SRC_H palette-indexed ROM image across the SCREEN_W x SCREEN_H display.
- Adds three things beyond a fixed stretch: a frame-synchronous horizontal pan for camera sweep, a frame-stepped fade-in/fade-out state machine, and a transparency flag for the downstream compositor.
- Sits between the VGA timing generator and the sprite/palette layer compositor. The image ROM and palette are external, so one renderer serves every camera image.

Parameters:
- SRC_W, 320: source image width in pixels.
- SRC_H, 120: source image height in pixels.
- VIEW_W, 160: source columns visible at once. Must satisfy 1 <= VIEW_W <= SRC_W.
- SCREEN_W, 640: active display width.
- SCREEN_H, 480: active display height.
- IDX_W, 2: palette index width.
- ADDR_W, 16: ROM address width. Must satisfy 2^ADDR_W >= SRC_W*SRC_H.
- TRANSP_IDX, 0: palette index treated as transparent.
- STEP_FRAMES, 2: frames per fade level step. Must be >= 1.

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- pan_x  in  10  requested left source column.
- transp_en  in  1  enables the transparency flag.
- fade_in  in  1  pulse that starts a fade in.
- fade_out  in  1  pulse that starts a fade out.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_q  in  IDX_W  ROM data; valid exactly 1 cycle after rom_addr.
- pal_index  out  IDX_W  index presented to the external combinational palette.
- pal_red  in  4  palette red.
- pal_green  in  4  palette green.
- pal_blue  in  4  palette blue.
- red  out  4  output red.
- green  out  4  output green.
- blue  out  4  output blue.
- opaque  out  1  pixel is drawn; 0 lets lower layers show through.
- fade_level  out  5  current brightness, range 0..16.
- busy  out  1  high in FADE_IN or FADE_OUT.

Behaviour:
- Reset (asynchronous, reset_n low):
  - Clears rom_addr, red, green, blue, opaque, fade_level, busy, the pipeline flags, pan_lat and the step counter.
  - FSM enters OFF.
- Pan latch:
  - pan_lat is loaded only on a cycle with frame_start high, so a pan never changes mid-frame.
  - Loaded value is min(pan_x, SRC_W-VIEW_W).
- Address stage (cycle t+1):
  - src_x = pan_lat + (DrawX*VIEW_W)/SCREEN_W
  - src_y = (DrawY*SRC_H)/SCREEN_H
  - Both divisions are integer floor. Intermediate products are at least 20 bits wide so nothing truncates.
  - rom_addr <= src_y*SRC_W + src_x.
  - blank is delayed alongside as v1.
  - If blank is low, rom_addr holds its previous value.
- ROM stage (cycle t+2):
  - rom_q is valid. pal_index = rom_q, combinational.
  - v1 is delayed to v2.
- Output stage (cycle t+3):
  - If v2 = 0: red, green and blue are 0; opaque = 0.
  - Otherwise each channel = (pal_c * fade_level) >> 4, where the product is 9 bits wide.
  - opaque = ~(transp_en & (rom_q == TRANSP_IDX)).
  - When opaque is 0, RGB is also forced to 0.
- Total latency from DrawX/DrawY/blank to RGB: 3 cycles.
- Fade FSM (level changes take effect only at frame boundaries):
  - OFF: fade_level = 0. fade_in -> FADE_IN, step counter cleared.
  - FADE_IN: on frame_start, step counter increments. When it reaches STEP_FRAMES-1 it wraps to 0 and fade_level += 1. At 16 -> ON.
  - ON: fade_level = 16. fade_out -> FADE_OUT, step counter cleared.
  - FADE_OUT: mirror of FADE_IN, decrementing. At 0 -> OFF.
  - A fade_out during FADE_IN reverses direction from the current level; a fade_in during FADE_OUT does the same. The step counter is cleared on reversal.
  - fade_in while ON and fade_out while OFF are ignored.
  - fade_in and fade_out high in the same cycle: fade_out wins.
- fade_level never leaves 0..16. busy = (state is FADE_IN or FADE_OUT).
- Reset asserted mid-fade or mid-frame returns to OFF with black output. The first latched pan after release occurs at the next frame_start.

Test Plan:
1. Reset, then fade_in and 32 frame_start pulses with STEP_FRAMES=2 -> fade_level goes 0, 1 ... 16 every 2 frames; busy drops and FSM enters ON exactly when the level reaches 16.
2. State ON, pan_x=0, DrawX=639, DrawY=479, blank=1 -> rom_addr = 119*320 + 159 = 38239 one cycle later; RGB equals palette RGB 3 cycles after input.
3. pan_x=500 latched at frame_start -> pan clamps to 160; DrawX=0, DrawY=0 gives rom_addr = 160. pan_x changed mid-frame -> rom_addr unaffected until the next frame_start.
4. fade_level = 8, pal_red = 15 -> red = 7. blank=0 -> red = green = blue = 0 and opaque = 0.
5. transp_en=1, rom_q=0 -> opaque=0 and RGB=0. transp_en=0 with the same rom_q -> opaque=1 with palette colour.
6. fade_out issued at level 10 during FADE_IN, then reset_n pulsed low mid-fade -> level decrements from 10; after reset, fade_level=0, state OFF and outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/scaled_view_renderer.sv
// scaled_view_renderer
//   Full-screen background renderer. Stretches a VIEW_W x SRC_H window of a
//   palette-indexed ROM image over the SCREEN_W x SCREEN_H display. It adds a
//   horizontal pan that is latched once per frame, a fade-in/out brightness
//   FSM that steps once per frame, and an opaque flag for the layer compositor.
//
// Ports
//   vga_clk, reset_n             pixel clock, async active-low reset
//   DrawX, DrawY, blank          raster position and active-video flag
//   frame_start                  one-cycle pulse at the start of each frame
//   pan_x                        requested left source column
//   transp_en                    enables TRANSP_IDX transparency
//   fade_in, fade_out            fade request pulses
//   rom_addr / rom_q             external image ROM (1-cycle read latency)
//   pal_index / pal_red..blue    external combinational palette
//   red, green, blue, opaque     pixel out, 3 cycles after DrawX/DrawY/blank
//   fade_level, busy             brightness 0..16, fade in progress
//
// Fade FSM
//   state      | meaning
//   S_OFF      | black, fade_level = 0
//   S_FADE_IN  | fade_level rises one step every STEP_FRAMES frames
//   S_ON       | full brightness, fade_level = 16
//   S_FADE_OUT | fade_level falls one step every STEP_FRAMES frames
module scaled_view_renderer #(
  parameter int SRC_W       = 320,
  parameter int SRC_H       = 120,
  parameter int VIEW_W      = 160,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int IDX_W       = 2,
  parameter int ADDR_W      = 16,
  parameter int TRANSP_IDX  = 0,
  parameter int STEP_FRAMES = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pan_x,
  input  logic              transp_en,
  input  logic              fade_in,
  input  logic              fade_out,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque,
  output logic [4:0]        fade_level,
  output logic              busy
);

  localparam int PAN_MAX = SRC_W - VIEW_W;
  localparam int CNT_W   = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);
  localparam logic [4:0] LVL_MAX = 5'd16;

  typedef enum logic [1:0] {S_OFF, S_FADE_IN, S_ON, S_FADE_OUT} state_t;

  state_t             state_q, state_d;
  logic [4:0]         level_q, level_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [9:0]         pan_lat_q, pan_lat_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               v1_q, v2_q;
  logic [3:0]         red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               opaque_q, opaque_d;
  logic [31:0]        src_x, src_y;
  logic               transp_hit;

  // 9-bit product keeps 15*16 exact; the top nibble of the low byte is the result.
  function automatic logic [3:0] scale_c(input logic [3:0] c, input logic [4:0] lvl);
    logic [8:0] p;
    p = 9'(c) * 9'(lvl);
    return 4'(p >> 4);
  endfunction

  // Pan only moves at a frame boundary so the image never tears mid-frame.
  always_comb begin
    pan_lat_d = pan_lat_q;
    if (frame_start)
      pan_lat_d = (32'(pan_x) > 32'(PAN_MAX)) ? 10'(PAN_MAX) : pan_x;
  end

  assign src_x = 32'(pan_lat_q) + (32'(DrawX) * 32'(VIEW_W)) / 32'(SCREEN_W);
  assign src_y = (32'(DrawY) * 32'(SRC_H)) / 32'(SCREEN_H);
  assign rom_addr_d = blank ? ADDR_W'(src_y * 32'(SRC_W) + src_x) : rom_addr_q;

  assign pal_index  = rom_q;
  assign transp_hit = transp_en & (rom_q == IDX_W'(TRANSP_IDX));

  always_comb begin
    opaque_d = v2_q & ~transp_hit;
    red_d    = opaque_d ? scale_c(pal_red,   level_q) : 4'd0;
    green_d  = opaque_d ? scale_c(pal_green, level_q) : 4'd0;
    blue_d   = opaque_d ? scale_c(pal_blue,  level_q) : 4'd0;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pan_lat_q  <= '0;
      rom_addr_q <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      opaque_q   <= 1'b0;
    end else begin
      pan_lat_q  <= pan_lat_d;
      rom_addr_q <= rom_addr_d;
      v1_q       <= blank;
      v2_q       <= v1_q;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      opaque_q   <= opaque_d;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_OFF;
      level_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      step_q  <= step_d;
    end
  end

  // fade_out is tested first everywhere so it wins a simultaneous request.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d  = step_q;
    case (state_q)
      S_OFF: begin
        level_d = '0;
        if (fade_in && !fade_out) begin
          state_d = S_FADE_IN;
          step_d  = '0;
        end
      end
      S_FADE_IN: begin
        if (fade_out) begin
          state_d = S_FADE_OUT;
          step_d  = '0;
        end else if (level_q >= LVL_MAX) begin
          state_d = S_ON;
        end else if (frame_start) begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            level_d = level_q + 5'd1;
            if (level_q == LVL_MAX - 5'd1) state_d = S_ON;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      S_ON: begin
        level_d = LVL_MAX;
        if (fade_out) begin
          state_d = S_FADE_OUT;
          step_d  = '0;
        end
      end
      S_FADE_OUT: begin
        if (fade_in && !fade_out) begin
          state_d = S_FADE_IN;
          step_d  = '0;
        end else if (level_q == 5'd0) begin
          state_d = S_OFF;
        end else if (frame_start) begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            level_d = level_q - 5'd1;
            if (level_q == 5'd1) state_d = S_OFF;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    busy = (state_q == S_FADE_IN) || (state_q == S_FADE_OUT);
  end

  assign rom_addr   = rom_addr_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign opaque     = opaque_q;
  assign fade_level = level_q;

endmodule
